c17_pipe_array: RTL
===================

// Module: c17_pipe_array
// PURPOSE
// - Pipelined, multi-channel successor to the c17 benchmark netlist: CHANNELS independent c17 cones
//   evaluated per transaction.
// - Results registered through STAGES valid/ready pipeline stages, giving the STA flow reg-to-reg paths
//   and back-pressure logic to analyse.
// - Sits between a vector source (bench or scan driver) and a result sink; keeps a saturating count of
//   delivered results.
// PARAMETERS
// - CHANNELS  4   number of parallel c17 cones; each channel-packed port is CHANNELS bits, bit i = channel i
// - STAGES    2   pipeline register stages, legal 1..4; accept-to-out_valid latency in cycles
// - COUNT_W   16  width of the delivered-result counter
// PORTS
// - clk        in   1         rising-edge clock
// - rst_n      in   1         synchronous, active-low reset
// - in_valid   in   1         input vector valid
// - in_ready   out  1         block can accept a vector this cycle
// - in_n1      in   CHANNELS  c17 input N1, per channel
// - in_n2      in   CHANNELS  c17 input N2
// - in_n3      in   CHANNELS  c17 input N3
// - in_n6      in   CHANNELS  c17 input N6
// - in_n7      in   CHANNELS  c17 input N7
// - out_valid  out  1         result valid
// - out_ready  in   1         sink accepts the result
// - out_n22    out  CHANNELS  c17 output N22
// - out_n23    out  CHANNELS  c17 output N23
// - out_n10    out  CHANNELS  internal node n10, exported for observability
// - res_count  out  COUNT_W   results delivered, saturating at all-ones
// BEHAVIOUR
// - Per-channel function, computed combinationally ahead of stage 0:
//     n10 = ~(N3&N6)
//     N22 = (N1&N3) | (N2&n10)
//     N23 = n10 & (N2|N7)
// - Stage k holds valid_k plus a 3*CHANNELS-bit data word.
//   - Final stage drives out_valid/out_n*.
//   - Stage k loads from stage k-1 (stage 0 from the input) when: valid_k==0, or stage k transfers
//     this cycle.
// - Handshake:
//   - Input accepted when in_valid & in_ready.
//   - Output transferred when out_valid & out_ready.
//   - in_ready = ~valid_0 | stage 0 advancing. Full-throughput: 1 vector/cycle with out_ready held high.
//   - out_valid and out_n* stay stable while out_valid & ~out_ready.
//   - Input data is ignored when in_valid is low.
// - Latency: a vector accepted in cycle t with an empty pipe appears with out_valid=1 in cycle t+STAGES.
// - Ordering: results leave in acceptance order; no drop, no duplication.
// - Bubbles collapse: a non-valid stage always loads, so a stalled head still lets upstream stages fill.
//   Total capacity = STAGES vectors.
// - Full pipe with out_ready=0: in_ready=0.
//   - Simultaneous output transfer and input accept while full is legal and keeps occupancy at STAGES.
// - res_count increments by 1 on each output transfer; it holds at 2^COUNT_W-1 once reached (no wrap).
// - Reset (rst_n=0 at a clk edge):
//   - All valid_k clear, so out_valid=0.
//   - Data registers and out_n22/out_n23/out_n10 clear to 0; res_count=0.
//   - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
// - Reset mid-operation discards all in-flight vectors with no output transfer.
// - X on in_n* while in_valid=0 must not propagate to out_valid or res_count.
// TESTING
// - Single vector, ch0 N1..N7 = 1,0,1,1,0, STAGES=2 -> out_valid at t+2; ch0 N22=1, N23=0, n10=0.
// - ch0 all-zero, ch1 N2=1 only, ch2 N3=N6=N7=1, ch3 N1=N3=1 -> N22=0,1,0,1; N23=0,1,0,0;
//   n10=1,1,0,1.
// - Streaming: 10 back-to-back vectors, out_ready=1 -> in_ready stays 1; outputs in order on 10
//   consecutive cycles; res_count=10.
// - Back-pressure: out_ready=0 while 5 vectors are offered -> 2 accepted, then in_ready=0 and outputs
//   held stable; release -> all 5 emerge in order.
// - Reset mid-stream with 2 vectors in flight -> out_valid=0 next cycle; res_count=0; no stale result
//   after release.
// - Saturation with COUNT_W=3: 9 transfers -> res_count reaches 7 and stays at 7.

Source files
------------

// File: rtl/c17_pipe_array.sv
// c17_pipe_array: CHANNELS parallel c17 cones behind a STAGES-deep valid/ready pipeline.
// Keeps a saturating count of the results delivered to the sink.
module c17_pipe_array #(
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2,
    parameter int COUNT_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [CHANNELS-1:0] i_in_n1,
    input  logic [CHANNELS-1:0] i_in_n2,
    input  logic [CHANNELS-1:0] i_in_n3,
    input  logic [CHANNELS-1:0] i_in_n6,
    input  logic [CHANNELS-1:0] i_in_n7,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [CHANNELS-1:0] o_out_n22,
    output logic [CHANNELS-1:0] o_out_n23,
    output logic [CHANNELS-1:0] o_out_n10,
    output logic [COUNT_W-1:0]  o_res_count
);
    localparam int W = 3 * CHANNELS;
    logic [CHANNELS-1:0] w_n10;
    logic [W-1:0]        w_din;
    logic [STAGES-1:0]   r_valid;
    logic [W-1:0]        r_data [STAGES];
    logic [STAGES-1:0]   w_load;
    logic [STAGES:0]     w_vchain;
    logic [W-1:0]        w_dchain [STAGES+1];
    logic                w_free;
    logic                w_out_xfer;
    logic [COUNT_W-1:0]  r_count;
    assign w_n10 = ~(i_in_n3 & i_in_n6);
    assign w_din = {w_n10, w_n10 & (i_in_n2 | i_in_n7), (i_in_n1 & i_in_n3) | (i_in_n2 & w_n10)};
    assign w_vchain = {r_valid, i_in_valid};
    assign w_dchain[0] = w_din;
    for (genvar g = 0; g < STAGES; g++) begin : g_chain
        assign w_dchain[g+1] = r_data[g];
    end
    // A stage may load if it or any stage downstream of it is empty, or the sink takes the head.
    always_comb begin
        w_load = '0;
        w_free = i_out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_free    = w_free | ~r_valid[k];
            w_load[k] = w_free;
        end
    end
    assign w_out_xfer  = r_valid[STAGES-1] & i_out_ready;
    assign o_in_ready  = i_rst_n & w_load[0];
    assign o_out_valid = r_valid[STAGES-1];
    assign o_out_n22   = r_data[STAGES-1][CHANNELS-1:0];
    assign o_out_n23   = r_data[STAGES-1][2*CHANNELS-1:CHANNELS];
    assign o_out_n10   = r_data[STAGES-1][W-1:2*CHANNELS];
    assign o_res_count = r_count;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_count <= '0;
            for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_vchain[k];
                    if (w_vchain[k]) r_data[k] <= w_dchain[k];
                end
            end
            if (w_out_xfer && r_count != '1) r_count <= r_count + 1'b1;
        end
    end
endmodule
